// File: rtl/invert_and_threshold_soc_elapsed_timer.sv
// Elapsed-cycle timer: reads a free-running AXI4 counter at start and stop
// events and reports the 48-bit modular difference with a sticky error flag.
module invert_and_threshold_soc_elapsed_timer #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int COUNTER_ADDR   = 0,
    parameter int TXN_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic                      o_busy,
    output logic [47:0]               o_elapsed,
    output logic                      o_elapsed_valid,
    input  logic                      i_elapsed_ready,
    output logic                      o_resp_err,
    output logic                      o_axi4init_arvalid,
    input  logic                      i_axi4init_arready,
    output logic [AXI_ADDR_WIDTH-1:0] o_axi4init_araddr,
    output logic [AXI_ID_WIDTH-1:0]   o_axi4init_arid,
    output logic [7:0]                o_axi4init_arlen,
    output logic [2:0]                o_axi4init_arsize,
    output logic [1:0]                o_axi4init_arburst,
    input  logic                      i_axi4init_rvalid,
    output logic                      o_axi4init_rready,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi4init_rdata,
    input  logic [AXI_ID_WIDTH-1:0]   i_axi4init_rid,
    input  logic [1:0]                i_axi4init_rresp,
    input  logic                      i_axi4init_rlast
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_AR_START = 3'd1;
    localparam logic [2:0] S_R_START  = 3'd2;
    localparam logic [2:0] S_RUNNING  = 3'd3;
    localparam logic [2:0] S_AR_STOP  = 3'd4;
    localparam logic [2:0] S_R_STOP   = 3'd5;
    localparam logic [2:0] S_OUT      = 3'd6;

    logic [2:0]  r_state;
    logic        r_stop_pending;
    logic [47:0] r_start_ts;
    logic        r_start_err;

    logic        w_r_hs;
    logic        w_rerr;
    logic [47:0] w_rdata;
    logic        w_unused;

    assign o_axi4init_araddr  = AXI_ADDR_WIDTH'(COUNTER_ADDR);
    assign o_axi4init_arid    = AXI_ID_WIDTH'(TXN_ID);
    assign o_axi4init_arlen   = 8'd0;
    assign o_axi4init_arsize  = 3'd3;
    assign o_axi4init_arburst = 2'b01;

    assign o_axi4init_arvalid = (r_state == S_AR_START) || (r_state == S_AR_STOP);
    assign o_axi4init_rready  = (r_state == S_R_START) || (r_state == S_R_STOP);
    assign o_busy             = (r_state != S_IDLE);

    assign w_r_hs  = i_axi4init_rvalid && o_axi4init_rready;
    assign w_rerr  = (i_axi4init_rresp != 2'b00);
    assign w_rdata = i_axi4init_rdata[47:0];

    // Only the low 48 counter bits, and neither rid nor rlast, matter here.
    assign w_unused = ^{i_axi4init_rid, i_axi4init_rlast,
                        i_axi4init_rdata[AXI_DATA_WIDTH-1:48]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_stop_pending  <= 1'b0;
            r_start_ts      <= 48'd0;
            r_start_err     <= 1'b0;
            o_elapsed       <= 48'd0;
            o_elapsed_valid <= 1'b0;
            o_resp_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state        <= S_AR_START;
                        r_stop_pending <= i_stop;
                    end
                end
                S_AR_START: begin
                    if (i_stop) r_stop_pending <= 1'b1;
                    if (i_axi4init_arready) r_state <= S_R_START;
                end
                S_R_START: begin
                    if (w_r_hs) begin
                        r_start_ts     <= w_rdata;
                        r_start_err    <= w_rerr;
                        r_stop_pending <= 1'b0;
                        // A stop landing on the capture cycle must not be lost.
                        r_state <= (r_stop_pending || i_stop) ? S_AR_STOP : S_RUNNING;
                    end else if (i_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (i_stop) r_state <= S_AR_STOP;
                end
                S_AR_STOP: begin
                    if (i_axi4init_arready) r_state <= S_R_STOP;
                end
                S_R_STOP: begin
                    if (w_r_hs) begin
                        o_elapsed       <= w_rdata - r_start_ts;
                        o_resp_err      <= r_start_err || w_rerr;
                        o_elapsed_valid <= 1'b1;
                        r_state         <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_elapsed_ready) begin
                        o_elapsed_valid <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
